// File: rtl/icache_miss_sequencer.sv
// Merges per-port I-cache line misses into an MSHR file, issues them in allocation order on a tagged
// memory port (combinational request, retried while the tag is 0) and returns refills one cycle after the response.
module icache_miss_sequencer #(
    parameter int NUM_MSHR  = 4,
    parameter int TAG_BITS  = 4,
    parameter int LINE_BITS = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush_i,
    input  logic [1:0]           miss_valid_i,
    input  logic [1:0][31:0]     miss_addr_i,
    output logic                 mem_req_valid_o,
    output logic [31:0]          mem_req_addr_o,
    input  logic [TAG_BITS-1:0]  mem_req_tag_i,
    input  logic [TAG_BITS-1:0]  mem_rsp_tag_i,
    input  logic [LINE_BITS-1:0] mem_rsp_data_i,
    output logic                 fill_valid_o,
    output logic [31:0]          fill_addr_o,
    output logic [LINE_BITS-1:0] fill_data_o,
    output logic                 mshr_full_o,
    output logic                 busy_o
);
    localparam int IW = $clog2(NUM_MSHR);
    localparam int CW = $clog2(NUM_MSHR + 1);

    typedef enum logic [1:0] {
        E_FREE = 2'd0,
        E_PEND = 2'd1,
        E_WAIT = 2'd2
    } ent_state_e;

    ent_state_e           state_q [NUM_MSHR];
    logic [28:0]          line_q  [NUM_MSHR];
    logic [TAG_BITS-1:0]  tag_q   [NUM_MSHR];
    logic [NUM_MSHR-1:0]  squash_q;
    logic [IW-1:0]        queue_q [NUM_MSHR];
    logic [IW-1:0]        head_q;
    logic [CW-1:0]        count_q;
    logic                 fill_valid_q;
    logic [28:0]          fill_line_q;
    logic [LINE_BITS-1:0] fill_data_q;
    logic [NUM_MSHR-1:0]  live_wait_q;
    logic [IW-1:0]        fill_idx_q;

    logic [1:0][28:0]     miss_line;
    logic [1:0]           dup;
    logic [1:0]           alloc_vld;
    logic [1:0][IW-1:0]   alloc_idx;
    logic                 rsp_hit;
    logic [IW-1:0]        rsp_idx;
    logic [IW-1:0]        head_idx;
    logic                 accept;
    logic [IW-1:0]        tail0;
    logic [IW-1:0]        tail1;
    logic [NUM_MSHR-1:0]  not_free;
    logic [NUM_MSHR-1:0]  live_wait;
    logic [CW-1:0]        pend_cnt;
    logic                 unused_addr_bits;

    assign miss_line[0]     = miss_addr_i[0][31:3];
    assign miss_line[1]     = miss_addr_i[1][31:3];
    assign unused_addr_bits = ^{miss_addr_i[0][2:0], miss_addr_i[1][2:0]};

    always_comb begin
        not_free  = '0;
        live_wait = '0;
        pend_cnt  = '0;
        for (int i = 0; i < NUM_MSHR; i++) begin
            not_free[i]  = (state_q[i] != E_FREE);
            live_wait[i] = (state_q[i] == E_WAIT) && !squash_q[i];
            pend_cnt     = pend_cnt + CW'(state_q[i] == E_PEND);
        end
    end

    // Squashed entries are invisible to duplicate matching so a redirected fetch can re-miss.
    always_comb begin
        dup = '0;
        for (int p = 0; p < 2; p++) begin
            if (fill_valid_q && (fill_line_q == miss_line[p])) dup[p] = 1'b1;
            for (int i = 0; i < NUM_MSHR; i++) begin
                if (not_free[i] && !squash_q[i] && (line_q[i] == miss_line[p])) dup[p] = 1'b1;
            end
        end
        if (miss_valid_i[0] && (miss_line[1] == miss_line[0])) dup[1] = 1'b1;
    end

    always_comb begin
        alloc_vld = '0;
        alloc_idx = '0;
        for (int p = 0; p < 2; p++) begin
            if (miss_valid_i[p] && !dup[p] && !flush_i) begin
                for (int i = NUM_MSHR - 1; i >= 0; i--) begin
                    if (!not_free[i] && !(p == 1 && alloc_vld[0] && alloc_idx[0] == IW'(i))) begin
                        alloc_vld[p] = 1'b1;
                        alloc_idx[p] = IW'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        rsp_hit = 1'b0;
        rsp_idx = '0;
        for (int i = 0; i < NUM_MSHR; i++) begin
            if ((mem_rsp_tag_i != '0) && (state_q[i] == E_WAIT) && (tag_q[i] == mem_rsp_tag_i)) begin
                rsp_hit = 1'b1;
                rsp_idx = IW'(i);
            end
        end
    end

    assign head_idx        = queue_q[head_q];
    assign mem_req_valid_o = (count_q != '0) && !flush_i && !reset;
    assign mem_req_addr_o  = {line_q[head_idx], 3'b000};
    assign accept          = mem_req_valid_o && (mem_req_tag_i != '0);
    assign tail0           = head_q + IW'(count_q);
    assign tail1           = tail0 + IW'(alloc_vld[0]);

    assign fill_valid_o = fill_valid_q;
    assign fill_addr_o  = {fill_line_q, 3'b000};
    assign fill_data_o  = fill_data_q;
    assign mshr_full_o  = &not_free;
    assign busy_o       = |not_free;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_MSHR; i++) begin
                state_q[i] <= E_FREE;
                line_q[i]  <= '0;
                tag_q[i]   <= '0;
                queue_q[i] <= '0;
            end
            squash_q     <= '0;
            head_q       <= '0;
            count_q      <= '0;
            fill_valid_q <= 1'b0;
            fill_line_q  <= '0;
            fill_data_q  <= '0;
            live_wait_q  <= '0;
            fill_idx_q   <= '0;
        end else begin
            live_wait_q  <= live_wait;
            fill_idx_q   <= rsp_idx;
            fill_valid_q <= rsp_hit && !squash_q[rsp_idx] && !flush_i;
            if (flush_i) begin
                for (int i = 0; i < NUM_MSHR; i++) begin
                    if (state_q[i] == E_PEND) state_q[i] <= E_FREE;
                    else if (state_q[i] == E_WAIT) squash_q[i] <= 1'b1;
                end
                head_q  <= '0;
                count_q <= '0;
            end else begin
                if (accept) begin
                    state_q[head_idx] <= E_WAIT;
                    tag_q[head_idx]   <= mem_req_tag_i;
                end
                for (int p = 0; p < 2; p++) begin
                    if (alloc_vld[p]) begin
                        state_q[alloc_idx[p]]  <= E_PEND;
                        line_q[alloc_idx[p]]   <= miss_line[p];
                        squash_q[alloc_idx[p]] <= 1'b0;
                    end
                end
                if (alloc_vld[0]) queue_q[tail0] <= alloc_idx[0];
                if (alloc_vld[1]) queue_q[tail1] <= alloc_idx[1];
                head_q  <= head_q + IW'(accept);
                count_q <= count_q - CW'(accept) + CW'(alloc_vld[0]) + CW'(alloc_vld[1]);
            end
            // The responding entry is released last so it wins over the flush squash.
            if (rsp_hit) begin
                state_q[rsp_idx]  <= E_FREE;
                squash_q[rsp_idx] <= 1'b0;
                fill_line_q       <= line_q[rsp_idx];
                fill_data_q       <= mem_rsp_data_i;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (pend_cnt == count_q);
            assert (!fill_valid_q || live_wait_q[fill_idx_q]);
            for (int i = 0; i < NUM_MSHR; i++) begin
                for (int j = i + 1; j < NUM_MSHR; j++) begin
                    assert (!(state_q[i] == E_WAIT && state_q[j] == E_WAIT && tag_q[i] == tag_q[j]));
                end
            end
        end
    end
endmodule
